imm_gen_stage: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage of the pipelined RISC-V core.
- Accepts a 32-bit instruction with valid/ready handshake, classifies its format and produces an XLEN-wide immediate.
- Fixes JALR to I-type extraction and adds U-type support.
- Holds results in a 2-entry skid buffer so back-pressure does not create a combinational ready path; supports a pipeline flush.

---
 rtl/imm_gen_pkg.sv | 25 ++
 rtl/imm_gen_stage_decode.sv | 52 +++++
 rtl/imm_gen_stage.sv | 82 ++++++++
 tb/tb_imm_gen_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes and format codes shared by the immediate generator
package imm_gen_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;
endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational instruction format classifier and immediate extractor
// Optional: IMM_GEN_CSR_ZIMM_EN enables FMT_Z (CSR zimm) for SYSTEM with funct3[2]=1.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);
    // Classify by opcode and sign-extend the reassembled immediate field to XLEN
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OP_OP: fmt = FMT_R;
            OP_FENCE: fmt = FMT_NONE;
`ifdef IMM_GEN_CSR_ZIMM_EN
            OP_SYSTEM: begin
                fmt = instr[14] ? FMT_Z : FMT_NONE;
                imm = instr[14] ? XLEN'(instr[19:15]) : '0;
            end
`else
            OP_SYSTEM: fmt = FMT_NONE;
`endif
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid buffer and flush
// Optional: IMM_GEN_CSR_ZIMM_EN (passed to imm_decode) adds CSR zimm decoding.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit PASS_INSTR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output fmt_e            out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [31:0]     instr;
    } ent_t;

    localparam ent_t ENT_ZERO = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, instr: '0};

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    ent_t            w_new;
    logic            w_accept;
    logic            w_main_load;
    ent_t            r_main;
    ent_t            r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (w_imm),
        .fmt     (w_fmt),
        .illegal (w_illegal)
    );

    assign w_new       = '{imm: w_imm, fmt: w_fmt, illegal: w_illegal, instr: PASS_INSTR ? in_instr : 32'd0};
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_main_load = !r_main_valid || out_ready;

    // Main register refills from skid first (FIFO order), else from the input; skid catches input only when main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= ENT_ZERO;
            r_skid       <= ENT_ZERO;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= ENT_ZERO;
            r_skid       <= ENT_ZERO;
        end else if (w_main_load) begin
            r_main_valid <= r_skid_valid || w_accept;
            r_skid_valid <= 1'b0;
            if (r_skid_valid) r_main <= r_skid;
            else if (w_accept) r_main <= w_new;
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_main_valid;
    assign out_imm     = r_main.imm;
    assign out_fmt     = r_main.fmt;
    assign out_illegal = r_main.illegal;
    assign out_instr   = r_main.instr;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: randomized and directed checks of imm_gen_stage against a queue-based reference
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid, out_illegal;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_imm, out_instr, out_instr64;
    logic [63:0] out_imm64;
    fmt_e        out_fmt, out_fmt64;

    int errors = 0;
    int checks = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .PASS_INSTR(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_instr(out_instr)
    );

    imm_gen_stage #(.XLEN(64), .PASS_INSTR(1)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_instr(out_instr64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] i, output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = $signed(i[31:20]); end
            7'h23: begin fmt = 3'd2; v = $signed({i[31:25], i[11:7]}); end
            7'h63: begin fmt = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h37, 7'h17: begin fmt = 3'd4; v = $signed(i[31:12]) * 4096; end
            7'h6F: begin fmt = 3'd5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'h33: fmt = 3'd6;
            7'h0F: fmt = 3'd0;
`ifdef IMM_GEN_CSR_ZIMM_EN
            7'h73: if (i[14]) begin fmt = 3'd7; v = i[19:15]; end
`else
            7'h73: fmt = 3'd0;
`endif
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    task automatic compare();
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid64", out_valid64, q.size() > 0);
        check("in_ready64", in_ready64, q.size() < 2);
        if (q.size() > 0) begin
            ref_dec(q[0], imm, fmt, ill);
            check("imm32", out_imm, imm[31:0]);
            check("imm64", out_imm64, imm);
            check("fmt", out_fmt, fmt);
            check("fmt64", out_fmt64, fmt);
            check("illegal", out_illegal, ill);
            check("instr", out_instr, q[0]);
            check("instr64", out_instr64, q[0]);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bit room;
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        room = q.size() < 2;
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (v && room) q.push_back(ins);
        end
        #1;
        compare();
    endtask

    logic [31:0] seq_in[4]  = '{32'hFE112E23, 32'h123452B7, 32'hFF9FF06F, 32'h00000863};
    logic [31:0] seq_imm[4] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8, 32'h00000010};
    logic [2:0]  seq_fmt[4] = '{3'd2, 3'd4, 3'd5, 3'd3};
    logic [6:0]  ops[12]    = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F};

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_imm", out_imm, 0);
        check("rst_fmt", out_fmt, FMT_NONE);
        check("rst_illegal", out_illegal, 0);
        check("rst_instr", out_instr, 0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1, 32'hFFF00093, 1, 0);
        check("addi_imm32", out_imm, 32'hFFFFFFFF);
        check("addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        check("addi_fmt", out_fmt, FMT_I);
        check("addi_illegal", out_illegal, 0);

        for (int i = 0; i < 4; i++) begin
            cycle(1, seq_in[i], 1, 0);
            check("b2b_valid", out_valid, 1);
            check("b2b_imm", out_imm, seq_imm[i]);
            check("b2b_fmt", out_fmt, seq_fmt[i]);
        end
        cycle(0, 0, 1, 0);

        cycle(1, 32'h00500093, 0, 0);
        cycle(1, 32'h00600113, 0, 0);
        check("hold_ready", in_ready, 0);
        cycle(1, 32'h00700193, 0, 0);
        check("hold_instr", out_instr, 32'h00500093);
        cycle(0, 0, 1, 0);
        check("drain_instr", out_instr, 32'h00600113);
        check("drain_ready", in_ready, 1);
        cycle(0, 0, 1, 0);
        check("drain_empty", out_valid, 0);

        cycle(1, 32'h00100093, 0, 0);
        cycle(1, 32'h00200093, 0, 0);
        cycle(1, 32'h00300093, 0, 1);
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        cycle(0, 0, 1, 0);
        check("flush_gone", out_valid, 0);

        cycle(1, 32'h0000007F, 1, 0);
        check("ill_flag", out_illegal, 1);
        check("ill_imm", out_imm, 0);
        check("ill_fmt", out_fmt, FMT_NONE);
        cycle(1, 32'h00000067, 1, 0);
        check("jalr_fmt", out_fmt, FMT_I);
        check("jalr_imm", out_imm, 0);
        cycle(1, 32'h0002D073, 1, 0);
`ifdef IMM_GEN_CSR_ZIMM_EN
        check("csr_fmt", out_fmt, FMT_Z);
        check("csr_imm", out_imm, 5);
`else
        check("csr_fmt", out_fmt, FMT_NONE);
        check("csr_imm", out_imm, 0);
`endif

        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom();
            cycle(1'($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 11)]},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        cycle(1, 32'h00100093, 0, 0);
        cycle(1, 32'h00200093, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_imm", out_imm, 0);
        check("arst_instr", out_instr, 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 32'hFFF00093, 1, 0);
        check("post_rst_imm", out_imm, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
